// File: rtl/muldiv_seq_pkg.sv
// Shared types for the sequential RV32M divide unit: op codes, FSM states, request metadata.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package muldiv_seq_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = 6;

  // Final iteration index of the restoring loop (one quotient bit per step).
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  INT_MIN   = {1'b1, {(XLEN-1){1'b0}}};

  // Matches the ALU_SEL_* ordering used for the RV32M divide group.
  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Everything about an accepted request that is needed after the loop.
  typedef struct packed {
    op_e  op;
    logic neg_q;  // negate the quotient at the end
    logic neg_r;  // negate the remainder at the end
  } meta_t;

  function automatic logic op_is_signed(input op_e op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_is_rem(input op_e op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

  // Absolute value for signed ops, raw value otherwise. INT_MIN maps to itself,
  // which is the correct unsigned magnitude 2^31.
  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic sgn);
    return (sgn && v[XLEN-1]) ? -v : v;
  endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// Request/response bundle between the pipeline (master) and the divide unit (slave).
// Latency: n/a (wires only).
// Backpressure: valid/ready on both the request and the response channel; flush aborts.
//
// Signals:
//   req_valid/req_ready/req_op/req_a/req_b : request channel
//   flush                                  : kill any in-flight operation
//   resp_valid/resp_ready/resp_data        : response channel
//   busy                                   : unit is not idle (pipeline stall)
interface muldiv_seq_if;
  import muldiv_seq_pkg::*;

  logic            req_valid;
  logic            req_ready;
  logic [1:0]      req_op;
  logic [XLEN-1:0] req_a;
  logic [XLEN-1:0] req_b;
  logic            flush;
  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_data;
  logic            busy;

  modport master (
    output req_valid, req_op, req_a, req_b, flush, resp_ready,
    input  req_ready, resp_valid, resp_data, busy
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, flush, resp_ready,
    output req_ready, resp_valid, resp_data, busy
  );

endinterface

// File: rtl/muldiv_seq_div_step.sv
// One restoring-division step: shift {rem,quo} left, trial-subtract the divisor, keep or restore.
// Latency: combinational.
// Backpressure: none.
//
// Ports:
//   i_rem, i_quo : partial remainder and quotient/dividend shift register
//   i_div        : divisor magnitude
//   o_rem, o_quo : values after this step
module div_step
  import muldiv_seq_pkg::*;
(
  input  logic [XLEN-1:0] i_rem,
  input  logic [XLEN-1:0] i_quo,
  input  logic [XLEN-1:0] i_div,
  output logic [XLEN-1:0] o_rem,
  output logic [XLEN-1:0] o_quo
);

  logic [XLEN:0] w_shift;
  logic [XLEN:0] w_trial;
  logic          w_fits;

  // The remainder is always below the divisor, so the shifted value fits in
  // XLEN+1 bits and the trial's top bit is a reliable sign.
  assign w_shift = {i_rem, i_quo[XLEN-1]};
  assign w_trial = w_shift - {1'b0, i_div};
  assign w_fits  = ~w_trial[XLEN];

  assign o_rem = w_fits ? w_trial[XLEN-1:0] : w_shift[XLEN-1:0];
  assign o_quo = {i_quo[XLEN-2:0], w_fits};

endmodule

// File: rtl/muldiv_seq.sv
// Sequential RV32M DIV/DIVU/REM/REMU unit using a 32-step restoring loop.
// Latency: response 33 cycles after acceptance; 1 cycle for divide-by-zero/overflow when EARLY_OUT.
// Backpressure: req_ready only in IDLE; result held in DONE until resp_ready; flush aborts.
//
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   io       : request/response bundle (slave side), see muldiv_seq_if
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter bit EARLY_OUT = 1'b1
) (
  input logic         clk,
  input logic         rst,
  muldiv_seq_if.slave io
);

  state_e          r_state;
  state_e          w_next_state;
  meta_t           r_meta;
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_quo;
  logic [XLEN-1:0] r_div;
  logic [XLEN-1:0] r_result;
  logic [CNT_W-1:0] r_cnt;

  op_e             w_op;
  logic            w_sgn;
  logic            w_accept;
  logic            w_div_zero;
  logic            w_ovf;
  logic            w_special;
  logic            w_last;
  logic [XLEN-1:0] w_special_res;
  logic [XLEN-1:0] w_step_rem;
  logic [XLEN-1:0] w_step_quo;
  logic [XLEN-1:0] w_fix_rem;
  logic [XLEN-1:0] w_fix_quo;
  logic [XLEN-1:0] w_final_res;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  assign w_op       = op_e'(io.req_op);
  assign w_sgn      = op_is_signed(w_op);
  assign w_div_zero = (io.req_b == '0);
  assign w_ovf      = w_sgn && (io.req_a == INT_MIN) && (io.req_b == '1);
  assign w_special  = EARLY_OUT && (w_div_zero || w_ovf);

  // Flush wins over a same-cycle request.
  assign w_accept = (r_state == ST_IDLE) && io.req_valid && !io.flush;

  always_comb begin
    w_special_res = '0;
    if (w_div_zero) begin
      w_special_res = op_is_rem(w_op) ? io.req_a : '1;
    end else if (w_ovf) begin
      w_special_res = op_is_rem(w_op) ? '0 : INT_MIN;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  assign w_last = (r_cnt == LAST_STEP);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state  = r_state;
    io.req_ready  = 1'b0;
    io.resp_valid = 1'b0;
    io.busy       = 1'b1;
    case (r_state)
      ST_IDLE: begin
        io.req_ready = 1'b1;
        io.busy      = 1'b0;
        if (io.req_valid) begin
          w_next_state = w_special ? ST_DONE : ST_CALC;
        end
      end
      ST_CALC: begin
        if (w_last) begin
          w_next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        io.resp_valid = 1'b1;
        if (io.resp_ready) begin
          w_next_state = ST_IDLE;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
    if (io.flush) begin
      w_next_state = ST_IDLE;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  div_step u_step (
    .i_rem (r_rem),
    .i_quo (r_quo),
    .i_div (r_div),
    .o_rem (w_step_rem),
    .o_quo (w_step_quo)
  );

  // Sign fix-up applied to the last step's output, so DONE holds the final value.
  assign w_fix_rem   = r_meta.neg_r ? -w_step_rem : w_step_rem;
  assign w_fix_quo   = r_meta.neg_q ? -w_step_quo : w_step_quo;
  assign w_final_res = op_is_rem(r_meta.op) ? w_fix_rem : w_fix_quo;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta   <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_div    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
    end else if (w_accept) begin
      r_meta.op <= w_op;
      // A zero divisor yields an all-ones quotient that must not be negated;
      // this keeps the non-early-out path on the architected result.
      r_meta.neg_q <= w_sgn && (io.req_a[XLEN-1] ^ io.req_b[XLEN-1]) && !w_div_zero;
      r_meta.neg_r <= w_sgn && io.req_a[XLEN-1];
      r_quo        <= mag(io.req_a, w_sgn);
      r_div        <= mag(io.req_b, w_sgn);
      r_rem        <= '0;
      r_cnt        <= '0;
      if (w_special) begin
        r_result <= w_special_res;
      end
    end else if ((r_state == ST_CALC) && !io.flush) begin
      r_rem <= w_step_rem;
      r_quo <= w_step_quo;
      r_cnt <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_result <= w_final_res;
      end
    end
  end

  assign io.resp_data = r_result;

endmodule
